// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared encodings for the N-channel arbiter
package arbitro_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACTIVE  = 2'b01,
    ST_BLOCKED = 2'b10
  } estado_t;
  localparam logic MODE_ROUTE = 1'b0;
  localparam logic MODE_RR    = 1'b1;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: rotate-priority picker; ports req (requests), ptr (start index), idx (grant index), any (some request)
module rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      j = j >= N ? j - N : j;
      if (req[PW'(j)]) idx = PW'(j);
    end
  end
  assign any = |req;
endmodule

// File: rtl/arbitro_n_canales.sv
// arbitro_n_canales: drains a FWFT FIFO into NUM_CH output FIFOs by destination field (ROUTE) or round-robin (RR)
//   in : clk, reset, mode, cnt_clr, data_in_arb, fifo_empty, fifos_almost_full
//   out: pop (comb), data_out_arb, push, cuenta, cuenta_drop, estado (all registered)
module arbitro_n_canales
  import arbitro_pkg::*;
#(
  parameter int WORD_SIZE = 12,
  parameter int NUM_CH    = 4,
  parameter int SEL_LSB   = 10,
  parameter int CNT_W     = 5,
  parameter bit STALL_ALL = 1'b0,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mode,
  input  logic                    cnt_clr,
  input  logic [WORD_SIZE-1:0]    data_in_arb,
  input  logic                    fifo_empty,
  input  logic [NUM_CH-1:0]       fifos_almost_full,
  output logic                    pop,
  output logic [WORD_SIZE-1:0]    data_out_arb,
  output logic [NUM_CH-1:0]       push,
  output logic [NUM_CH*CNT_W-1:0] cuenta,
  output logic [CNT_W-1:0]        cuenta_drop,
  output logic [1:0]              estado
);
  logic [SEL_W-1:0] sel, rr_idx, rr_ptr, tgt;
  logic [2**SEL_W-1:0] af_pad;
  logic in_range, route_ok, rr_any, ok, hit, drop;
  estado_t nxt;
  assign sel    = data_in_arb[SEL_LSB +: SEL_W];
  // Padding lets an out-of-range destination index the almost-full vector safely.
  assign af_pad = (2**SEL_W)'(fifos_almost_full);
  assign in_range = {1'b0, sel} < (SEL_W + 1)'(NUM_CH);
  // Out-of-range words are dropped, so they never wait on any channel.
  assign route_ok = !in_range || (STALL_ALL ? ~|fifos_almost_full : !af_pad[sel]);
  rr_pick #(.N(NUM_CH)) u_pick (
    .req (~fifos_almost_full),
    .ptr (rr_ptr),
    .idx (rr_idx),
    .any (rr_any)
  );
  assign tgt  = mode == MODE_RR ? rr_idx : sel;
  assign ok   = mode == MODE_RR ? rr_any : route_ok;
  assign pop  = !reset && !fifo_empty && ok;
  assign hit  = pop && (mode == MODE_RR || in_range);
  assign drop = pop && mode == MODE_ROUTE && !in_range;
  always_comb begin
    nxt = fifo_empty ? ST_IDLE : pop ? ST_ACTIVE : ST_BLOCKED;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      push         <= '0;
      data_out_arb <= '0;
      cuenta       <= '0;
      cuenta_drop  <= '0;
      rr_ptr       <= '0;
      estado       <= ST_IDLE;
    end else begin
      push   <= hit ? NUM_CH'(1) << tgt : '0;
      estado <= nxt;
      if (hit) data_out_arb <= data_in_arb;
      if (pop && mode == MODE_RR) rr_ptr <= rr_idx == SEL_W'(NUM_CH - 1) ? '0 : rr_idx + SEL_W'(1);
      for (int i = 0; i < NUM_CH; i++)
        cuenta[i*CNT_W +: CNT_W] <= cnt_clr ? '0 : cuenta[i*CNT_W +: CNT_W] + CNT_W'(hit && tgt == SEL_W'(i));
      cuenta_drop <= cnt_clr ? '0 : cuenta_drop + CNT_W'(drop);
    end
  end
endmodule
